// File: rtl/image_filter_pkg.sv
// Shared constants and helpers for the image filter pipeline stages.
`timescale 1ns/1ps
package image_filter_pkg;

    localparam int PIXEL_WIDTH_DEFAULT     = 8;
    localparam int PIXELS_PER_WORD_DEFAULT = 4;
    localparam int FRAME_COUNT_WIDTH       = 16;

    // Ceiling log2, never below 1 so a lane index always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_word_reg.sv
// Single-entry AXI4-Stream output holding register; "free" means a new word
// may be loaded on this clock edge.
`timescale 1ns/1ps
module axis_word_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [KEEP_WIDTH-1:0] load_keep,
    input  logic                  load_last,
    input  logic                  load_user,
    output logic                  free,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready
);

    // A drain and a reload in the same cycle keep tvalid high back-to-back.
    assign free = !m_axis_tvalid || m_axis_tready;

    // Output word register: loads take priority over a drain, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= {DATA_WIDTH{1'b0}};
            m_axis_tkeep  <= {KEEP_WIDTH{1'b0}};
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= load_data;
            m_axis_tkeep  <= load_keep;
            m_axis_tlast  <= load_last;
            m_axis_tuser  <= load_user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end else begin
            m_axis_tvalid <= m_axis_tvalid;
        end
    end

endmodule

// File: rtl/axis_pixel_packer.sv
// Packs a pixel stream little-endian into multi-lane AXI4-Stream words,
// closing words early at end-of-frame (and optionally end-of-line).
`timescale 1ns/1ps
module axis_pixel_packer
    import image_filter_pkg::*;
#(
    parameter int PIXEL_WIDTH     = PIXEL_WIDTH_DEFAULT,
    parameter int PIXELS_PER_WORD = PIXELS_PER_WORD_DEFAULT,
    parameter int LANE_LOG2       = clog2(PIXELS_PER_WORD),
    parameter bit FLUSH_ON_EOL    = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_axis_tvalid,
    input  logic [PIXEL_WIDTH-1:0]                 s_axis_tdata,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tuser,
    input  logic                                   s_axis_tlast,
    output logic                                   m_axis_tvalid,
    output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] m_axis_tdata,
    output logic [PIXELS_PER_WORD-1:0]             m_axis_tkeep,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tuser,
    output logic                                   m_axis_tlast,
    output logic [FRAME_COUNT_WIDTH-1:0]           frame_count,
    output logic                                   busy
);

    localparam int WORD_WIDTH = PIXEL_WIDTH * PIXELS_PER_WORD;
    localparam logic [LANE_LOG2-1:0] LAST_LANE = LANE_LOG2'(PIXELS_PER_WORD - 1);

    logic [LANE_LOG2-1:0]       lane;
    logic [WORD_WIDTH-1:0]      acc_data;
    logic [PIXELS_PER_WORD-1:0] acc_keep;
    logic [WORD_WIDTH-1:0]      merged_data;
    logic [PIXELS_PER_WORD-1:0] merged_keep;
    logic                       sof;
    logic                       free;
    logic                       accept;
    logic                       closing;
    logic                       close_word;

    assign s_axis_tready = free;
    assign accept        = s_axis_tvalid && free;
    assign closing       = (lane == LAST_LANE) || s_axis_tlast || (FLUSH_ON_EOL && s_axis_tuser);
    assign close_word    = accept && closing;
    assign busy          = (lane != {LANE_LOG2{1'b0}}) || m_axis_tvalid;

    // Accumulator with the incoming pixel merged into its current lane.
    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int k = 0; k < PIXELS_PER_WORD; k++) begin
            if (lane == LANE_LOG2'(k)) begin
                merged_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = s_axis_tdata;
                merged_keep[k]                            = 1'b1;
            end else begin
                merged_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = acc_data[k*PIXEL_WIDTH +: PIXEL_WIDTH];
                merged_keep[k]                            = acc_keep[k];
            end
        end
    end

    // Lane counter and accumulator; cleared on close so unused lanes stay zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane     <= {LANE_LOG2{1'b0}};
            acc_data <= {WORD_WIDTH{1'b0}};
            acc_keep <= {PIXELS_PER_WORD{1'b0}};
        end else if (close_word) begin
            lane     <= {LANE_LOG2{1'b0}};
            acc_data <= {WORD_WIDTH{1'b0}};
            acc_keep <= {PIXELS_PER_WORD{1'b0}};
        end else if (accept) begin
            lane     <= lane + LANE_LOG2'(1);
            acc_data <= merged_data;
            acc_keep <= merged_keep;
        end else begin
            lane     <= lane;
            acc_data <= acc_data;
            acc_keep <= acc_keep;
        end
    end

    // Start-of-frame flag: the word after a tlast word (or after reset) is SOF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof <= 1'b1;
        end else if (close_word) begin
            sof <= s_axis_tlast;
        end else begin
            sof <= sof;
        end
    end

    // Completed-frame counter, stepped on each delivered tlast word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= {FRAME_COUNT_WIDTH{1'b0}};
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
        end else begin
            frame_count <= frame_count;
        end
    end

    axis_word_reg #(
        .DATA_WIDTH (WORD_WIDTH),
        .KEEP_WIDTH (PIXELS_PER_WORD)
    ) u_word_reg (
        .clk           (clk),
        .rst           (rst),
        .load          (close_word),
        .load_data     (merged_data),
        .load_keep     (merged_keep),
        .load_last     (s_axis_tlast),
        .load_user     (sof),
        .free          (free),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Bench for axis_pixel_packer: one instance with EOL flush, one without, driven by
// directed and random frames and compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_axis_pixel_packer;

    localparam int NLANE       = 4;
    localparam int SOAK_FRAMES = 65537;
    localparam int RAND_FRAMES = 400;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic        last;
    } word_t;

    logic        clk;
    logic        rst;
    logic        s_tvalid [2];
    logic [7:0]  s_tdata  [2];
    logic        s_tready [2];
    logic        s_tuser  [2];
    logic        s_tlast  [2];
    logic        m_tvalid [2];
    logic [31:0] m_tdata  [2];
    logic [3:0]  m_tkeep  [2];
    logic        m_tready [2];
    logic        m_tuser  [2];
    logic        m_tlast  [2];
    logic [15:0] fcount   [2];
    logic        busy     [2];

    int     checks = 0;
    int     failures = 0;
    word_t  exp_q [2][$];
    logic [7:0] pend [2][$];
    bit     model_sof [2];
    int     exp_frames [2];
    int     rmode [2];
    int     gap_pct;
    beat_t  frame_q [$];
    word_t  prev_word [2];
    bit     prev_stall [2];

    axis_pixel_packer #(
        .PIXEL_WIDTH (8), .PIXELS_PER_WORD (4), .LANE_LOG2 (2), .FLUSH_ON_EOL (1'b1)
    ) dut_flush (
        .clk (clk), .rst (rst),
        .s_axis_tvalid (s_tvalid[0]), .s_axis_tdata (s_tdata[0]), .s_axis_tready (s_tready[0]),
        .s_axis_tuser (s_tuser[0]), .s_axis_tlast (s_tlast[0]),
        .m_axis_tvalid (m_tvalid[0]), .m_axis_tdata (m_tdata[0]), .m_axis_tkeep (m_tkeep[0]),
        .m_axis_tready (m_tready[0]), .m_axis_tuser (m_tuser[0]), .m_axis_tlast (m_tlast[0]),
        .frame_count (fcount[0]), .busy (busy[0])
    );

    axis_pixel_packer #(
        .PIXEL_WIDTH (8), .PIXELS_PER_WORD (4), .LANE_LOG2 (2), .FLUSH_ON_EOL (1'b0)
    ) dut_noflush (
        .clk (clk), .rst (rst),
        .s_axis_tvalid (s_tvalid[1]), .s_axis_tdata (s_tdata[1]), .s_axis_tready (s_tready[1]),
        .s_axis_tuser (s_tuser[1]), .s_axis_tlast (s_tlast[1]),
        .m_axis_tvalid (m_tvalid[1]), .m_axis_tdata (m_tdata[1]), .m_axis_tkeep (m_tkeep[1]),
        .m_axis_tready (m_tready[1]), .m_axis_tuser (m_tuser[1]), .m_axis_tlast (m_tlast[1]),
        .frame_count (fcount[1]), .busy (busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string tagd(input string base, input int d);
        return $sformatf("%s[%0d]", base, d);
    endfunction

    // Reference model: pixels pile up in a list; a word is the list packed
    // little-endian with one keep bit per pixel present.
    function automatic void model_emit(input int d, input logic last);
        word_t w;
        w = '0;
        for (int i = 0; i < pend[d].size(); i++) begin
            w.data = w.data | (32'(pend[d][i]) << (8 * i));
        end
        w.keep = 4'((1 << pend[d].size()) - 1);
        w.user = model_sof[d];
        w.last = last;
        exp_q[d].push_back(w);
        pend[d].delete();
        model_sof[d] = last;
    endfunction

    function automatic void model_beat(input int d, input beat_t b);
        pend[d].push_back(b.data);
        if (pend[d].size() == NLANE || b.last || (d == 0 && b.user)) begin
            model_emit(d, b.last);
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            pend[d].delete();
            model_sof[d]  = 1'b1;
            exp_frames[d] = 0;
        end
    endfunction

    task automatic push_beat(input logic [7:0] data, input logic user, input logic last);
        beat_t b;
        b.data = data;
        b.user = user;
        b.last = last;
        frame_q.push_back(b);
    endtask

    task automatic gen_frame(input int maxlen, input int user_pct);
        int len;
        len = int'($urandom_range(maxlen, 1));
        for (int i = 0; i < len; i++) begin
            push_beat(8'($urandom), int'($urandom_range(99)) < user_pct, i == len - 1);
        end
    endtask

    task automatic send_beat(input int d, input beat_t b);
        int waited;
        bit acc;
        waited = 0;
        acc = 1'b0;
        s_tvalid[d] = 1'b1;
        s_tdata[d]  = b.data;
        s_tuser[d]  = b.user;
        s_tlast[d]  = b.last;
        while (!acc) begin
            @(negedge clk);
            acc = s_tready[d];
            @(posedge clk);
            #1;
            if (!acc) begin
                waited++;
                if (waited >= 500) begin
                    check(tagd("accept_timeout", d), 32'(s_tready[d]), 32'd1);
                    acc = 1'b1;
                end
            end
        end
        s_tvalid[d] = 1'b0;
        s_tdata[d]  = 8'h00;
        s_tuser[d]  = 1'b0;
        s_tlast[d]  = 1'b0;
    endtask

    task automatic run_frame(input int d);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            model_beat(d, frame_q[i]);
            send_beat(d, frame_q[i]);
        end
        frame_q.delete();
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (exp_q[d].size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tagd("words_outstanding", d), 32'(exp_q[d].size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check(tagd("frame_count", d), 32'(fcount[d]), 32'(16'(exp_frames[d])));
        check(tagd("busy_idle", d), 32'(busy[d]), 32'd0);
    endtask

    // Downstream ready generator: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                case (rmode[d])
                    0:       m_tready[d] = 1'b1;
                    1:       m_tready[d] = 1'($urandom_range(1));
                    default: m_tready[d] = 1'b0;
                endcase
            end
        end
    end

    // Output monitor: ready rule, stability under stall, word scoreboard.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    prev_stall[d] = 1'b0;
                end else begin
                    check(tagd("ready_rule", d), 32'(s_tready[d]), 32'(!m_tvalid[d] || m_tready[d]));
                    if (prev_stall[d]) begin
                        check(tagd("hold_valid", d), 32'(m_tvalid[d]), 32'd1);
                        check(tagd("hold_data", d), m_tdata[d], prev_word[d].data);
                        check(tagd("hold_keep", d), 32'(m_tkeep[d]), 32'(prev_word[d].keep));
                        check(tagd("hold_user", d), 32'(m_tuser[d]), 32'(prev_word[d].user));
                        check(tagd("hold_last", d), 32'(m_tlast[d]), 32'(prev_word[d].last));
                    end
                    if (m_tvalid[d] && m_tready[d]) begin
                        if (exp_q[d].size() == 0) begin
                            check(tagd("unexpected_word", d), 32'(m_tvalid[d]), 32'd0);
                        end else begin
                            w = exp_q[d].pop_front();
                            check(tagd("word_data", d), m_tdata[d], w.data);
                            check(tagd("word_keep", d), 32'(m_tkeep[d]), 32'(w.keep));
                            check(tagd("word_user", d), 32'(m_tuser[d]), 32'(w.user));
                            check(tagd("word_last", d), 32'(m_tlast[d]), 32'(w.last));
                            if (w.last) exp_frames[d]++;
                        end
                    end
                    prev_word[d].data = m_tdata[d];
                    prev_word[d].keep = m_tkeep[d];
                    prev_word[d].user = m_tuser[d];
                    prev_word[d].last = m_tlast[d];
                    prev_stall[d]     = m_tvalid[d] && !m_tready[d];
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        gap_pct = 0;
        for (int d = 0; d < 2; d++) begin
            s_tvalid[d] = 1'b0;
            s_tdata[d]  = 8'h00;
            s_tuser[d]  = 1'b0;
            s_tlast[d]  = 1'b0;
            rmode[d]    = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check(tagd("rst_tvalid", d), 32'(m_tvalid[d]), 32'd0);
            check(tagd("rst_tdata", d), m_tdata[d], 32'd0);
            check(tagd("rst_tkeep", d), 32'(m_tkeep[d]), 32'd0);
            check(tagd("rst_frame_count", d), 32'(fcount[d]), 32'd0);
            check(tagd("rst_busy", d), 32'(busy[d]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check(tagd("ready_after_reset", d), 32'(s_tready[d]), 32'd1);
        @(posedge clk);
        #1;

        // Two full words, tlast on the 8th pixel.
        for (int i = 1; i <= 8; i++) push_beat(8'(i), 1'b0, i == 8);
        run_frame(0);
        drain(0);

        // Six-pixel line closed early by EOL on the flushing instance.
        for (int i = 0; i < 6; i++) push_beat(8'h10 + 8'(i), i == 5, 1'b0);
        run_frame(0);
        drain(0);

        // EOL ignored without flush; partial word at tlast, then SOF on next frame.
        for (int i = 0; i < 5; i++) push_beat(8'hA1 + 8'(i), i == 1, i == 4);
        for (int i = 0; i < 3; i++) push_beat(8'hB1 + 8'(i), 1'b0, i == 2);
        run_frame(1);
        drain(1);

        // Backpressure: downstream held off for 10 cycles while streaming.
        rmode[0] = 2;
        for (int i = 0; i < 12; i++) push_beat(8'h60 + 8'(i), 1'b0, i == 11);
        fork
            run_frame(0);
            begin
                repeat (10) @(posedge clk);
                rmode[0] = 0;
            end
        join
        drain(0);

        // Random frames on the non-flushing instance.
        rmode[1] = 1;
        gap_pct  = 30;
        for (int f = 0; f < 60; f++) begin
            gen_frame(12, 25);
            run_frame(1);
        end
        rmode[1] = 0;
        drain(1);
        gap_pct = 0;

        // Asynchronous reset after two pixels of a word.
        push_beat(8'h31, 1'b0, 1'b0);
        push_beat(8'h32, 1'b0, 1'b0);
        for (int i = 0; i < frame_q.size(); i++) send_beat(0, frame_q[i]);
        frame_q.delete();
        check("busy_partial[0]", 32'(busy[0]), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_tvalid[0]", 32'(m_tvalid[0]), 32'd0);
        check("midrst_tdata[0]", m_tdata[0], 32'd0);
        check("midrst_tkeep[0]", 32'(m_tkeep[0]), 32'd0);
        check("midrst_tuser[0]", 32'(m_tuser[0]), 32'd0);
        check("midrst_tlast[0]", 32'(m_tlast[0]), 32'd0);
        check("midrst_frame_count[0]", 32'(fcount[0]), 32'd0);
        check("midrst_busy[0]", 32'(busy[0]), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_beat(8'h41 + 8'(i), 1'b0, i == 3);
        run_frame(0);
        drain(0);

        // Random soak with random valid/ready, then full-rate one-pixel frames
        // until the frame counter has wrapped past 2^16.
        rmode[0] = 1;
        gap_pct  = 25;
        for (int f = 0; f < RAND_FRAMES; f++) begin
            gen_frame(10, 25);
            run_frame(0);
        end
        rmode[0] = 0;
        gap_pct  = 0;
        for (int f = 0; f < SOAK_FRAMES - 1 - RAND_FRAMES; f++) begin
            push_beat(8'($urandom), 1'($urandom_range(1)), 1'b1);
            run_frame(0);
        end
        drain(0);
        check("frame_count_wrap[0]", 32'(fcount[0]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
